// File: rtl/ws2811_serial_receiver.sv
// ws2811_serial_receiver
//
// Decodes a one-wire WS2811 NRZ stream into 24-bit GRB words. Each high pulse
// is measured in clock cycles and classified as 0, 1 or error. A long enough
// low gap closes the frame. A pass-through copy of the stream is regenerated
// with the first own_words words removed, as a chained pixel would do.
//
// Ports
//   clock        system clock (50 MHz nominal)
//   reset        asynchronous active-low reset
//   enable       1 = decode; 0 = FSM held in IDLE, bit/word state cleared
//   serial_in    asynchronous WS2811 data line
//   own_words    leading words of each frame that are not forwarded
//   pixel_data   last decoded word, MSB = first bit received
//   pixel_index  index of pixel_data within its frame
//   pixel_valid  1-cycle pulse when pixel_data/pixel_index update
//   frame_done   1-cycle pulse when the latch gap ends a frame
//   pixel_count  complete words in the frame just closed (with frame_done)
//   bit_error    1-cycle pulse: glitch, overlong high, or partial word at latch
//   serial_out   regenerated pass-through stream
//   db_serial    synchronized serial_in
//   db_state     FSM state encoding
//
// state | meaning
// ------+----------------------------------------------------
// IDLE  | no activity since reset/latch, waiting for a rise
// HIGH  | measuring a high pulse
// LOW   | measuring the low time after a bit, watching for latch
module ws2811_serial_receiver #(
    parameter int T_MIN_HIGH = 5,
    parameter int T_THRESH   = 21,
    parameter int T_MAX_HIGH = 50,
    parameter int T_RESET    = 2500,
    parameter int CNT_W      = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        serial_in,
    input  logic [7:0]  own_words,
    output logic [23:0] pixel_data,
    output logic [7:0]  pixel_index,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [7:0]  pixel_count,
    output logic        bit_error,
    output logic        serial_out,
    output logic        db_serial,
    output logic [1:0]  db_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HIGH = 2'b01,
        S_LOW  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(T_MIN_HIGH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(T_THRESH);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(T_MAX_HIGH);
    localparam logic [CNT_W-1:0] RESET_C  = CNT_W'(T_RESET);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT_C    = '1;

    state_t            state, state_next;
    logic              sync_q, serial_s, serial_prev;
    logic              rise, fall;
    logic [CNT_W-1:0]  high_cnt, low_cnt;
    logic [4:0]        bit_cnt;
    logic [23:0]       shift;
    logic [23:0]       shift_next;
    logic [7:0]        idx;
    logic              fwd, fwd_now;
    logic              fall_good, fall_bad, latch;
    logic              bit_val, word_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q      <= 1'b0;
            serial_s    <= 1'b0;
            serial_prev <= 1'b0;
        end else begin
            sync_q      <= serial_in;
            serial_s    <= sync_q;
            serial_prev <= serial_s;
        end
    end

    assign rise      = serial_s & ~serial_prev;
    assign fall      = ~serial_s & serial_prev;
    assign db_serial = serial_s;
    assign db_state  = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // The latch check comes before the rise check in LOW so that a rise on the
    // latch cycle closes the old frame and starts the new one from scratch.
    always_comb begin
        state_next = state;
        fall_good  = 1'b0;
        fall_bad   = 1'b0;
        latch      = 1'b0;
        if (!enable) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (rise) state_next = S_HIGH;
                S_HIGH: begin
                    if (fall) begin
                        state_next = S_LOW;
                        if (high_cnt < MIN_C || high_cnt > MAX_C) fall_bad = 1'b1;
                        else                                      fall_good = 1'b1;
                    end
                end
                S_LOW: begin
                    if (low_cnt == RESET_C) begin
                        latch      = 1'b1;
                        state_next = rise ? S_HIGH : S_IDLE;
                    end else if (rise) begin
                        state_next = S_HIGH;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign bit_val    = (high_cnt >= THRESH_C);
    assign shift_next = {shift[22:0], bit_val};
    assign word_done  = fall_good & (bit_cnt == 5'd23);

    // Forwarding decision for the pulse starting now; after a latch the word
    // index is already back at 0 for the new frame.
    assign fwd_now = latch ? (own_words == 8'd0) : (idx >= own_words);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            high_cnt <= '0;
            low_cnt  <= '0;
        end else if (!enable) begin
            high_cnt <= '0;
            low_cnt  <= '0;
        end else begin
            if (rise)
                high_cnt <= ONE_C;
            else if (state == S_HIGH && fall)
                high_cnt <= '0;
            else if (state == S_HIGH && high_cnt != SAT_C)
                high_cnt <= high_cnt + ONE_C;

            if (latch)
                low_cnt <= '0;
            else if (state == S_HIGH && fall)
                low_cnt <= ONE_C;
            else if (state == S_LOW && !rise)
                low_cnt <= low_cnt + ONE_C;
            else
                low_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            shift   <= '0;
            idx     <= '0;
            fwd     <= 1'b0;
        end else if (!enable) begin
            bit_cnt <= '0;
            shift   <= '0;
            idx     <= '0;
            fwd     <= 1'b0;
        end else if (latch) begin
            bit_cnt <= '0;
            shift   <= '0;
            idx     <= '0;
            fwd     <= rise ? fwd_now : 1'b0;
        end else begin
            if (rise) fwd <= fwd_now;
            if (fall_bad) begin
                bit_cnt <= '0;
                shift   <= '0;
            end else if (fall_good) begin
                shift <= shift_next;
                if (bit_cnt == 5'd23) begin
                    bit_cnt <= '0;
                    if (idx != 8'hFF) idx <= idx + 8'd1;
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pixel_data  <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            pixel_count <= '0;
            bit_error   <= 1'b0;
            serial_out  <= 1'b0;
        end else begin
            pixel_valid <= word_done;
            frame_done  <= latch;
            bit_error   <= fall_bad | (latch & (bit_cnt != 5'd0));
            serial_out  <= enable & serial_s & (rise ? fwd_now : fwd);
            if (word_done) begin
                pixel_data  <= shift_next;
                pixel_index <= idx;
            end
            if (latch) pixel_count <= idx;
        end
    end

endmodule

// File: tb/tb_ws2811_serial_receiver.sv
module tb_ws2811_serial_receiver;

    localparam int T_MIN_HIGH = 5;
    localparam int T_THRESH   = 21;
    localparam int T_MAX_HIGH = 50;
    localparam int T_RESET    = 2500;
    localparam int MAXN       = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        serial_in = 1'b0;
    logic [7:0]  own_words = 8'd0;
    logic [23:0] pixel_data;
    logic [7:0]  pixel_index;
    logic        pixel_valid;
    logic        frame_done;
    logic [7:0]  pixel_count;
    logic        bit_error;
    logic        serial_out;
    logic        db_serial;
    logic [1:0]  db_state;

    ws2811_serial_receiver dut (
        .clock(clock), .reset(reset), .enable(enable), .serial_in(serial_in),
        .own_words(own_words), .pixel_data(pixel_data), .pixel_index(pixel_index),
        .pixel_valid(pixel_valid), .frame_done(frame_done), .pixel_count(pixel_count),
        .bit_error(bit_error), .serial_out(serial_out), .db_serial(db_serial),
        .db_state(db_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    bit          line[$];
    bit          exp_pv[MAXN];
    bit          exp_fd[MAXN];
    bit          exp_be[MAXN];
    bit          exp_so[MAXN];
    logic [23:0] exp_pd[MAXN];
    logic [7:0]  exp_pi[MAXN];
    logic [7:0]  exp_pc[MAXN];

    logic [31:0] cap_pv[$];
    logic [15:0] cap_fd[$];
    int          so_high;
    int          be_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add_level(input bit v, input int n);
        repeat (n) line.push_back(v);
    endtask

    task automatic add_word(input logic [23:0] w, input bit last_low = 1'b1);
        for (int i = 23; i >= 0; i--) begin
            int h;
            h = w[i] ? 30 : 13;
            add_level(1'b1, h);
            if (i != 0 || last_low) add_level(1'b0, 62 - h);
        end
    endtask

    // Reference: walk the line as runs of high and low samples. Output
    // registered in response to sample k becomes visible after edge k+2.
    task automatic build_model();
        int n, i, s, nh, nl, t, idx, bits;
        logic [23:0] sh;
        bit active, fwd;
        n = line.size();
        for (int k = 0; k < n; k++) begin
            exp_pv[k] = 0; exp_fd[k] = 0; exp_be[k] = 0; exp_so[k] = 0;
            exp_pd[k] = '0; exp_pi[k] = '0; exp_pc[k] = '0;
        end
        idx = 0; bits = 0; sh = '0; active = 0; fwd = 0; i = 0;
        while (i < n) begin
            if (line[i]) begin
                s = i;
                while (i < n && line[i]) i++;
                nh  = i - s;
                fwd = (idx >= int'(own_words));
                for (int k = s; k < i; k++) if (k + 2 < n) exp_so[k + 2] = fwd;
                if (i < n) begin
                    t = i + 2;
                    active = 1;
                    if (nh < T_MIN_HIGH || nh > T_MAX_HIGH) begin
                        if (t < n) exp_be[t] = 1;
                        bits = 0; sh = '0;
                    end else begin
                        sh = {sh[22:0], (nh >= T_THRESH)};
                        bits++;
                        if (bits == 24) begin
                            if (t < n) begin
                                exp_pv[t] = 1; exp_pd[t] = sh; exp_pi[t] = 8'(idx);
                            end
                            bits = 0;
                            if (idx < 255) idx++;
                        end
                    end
                end
            end else begin
                s = i;
                while (i < n && !line[i]) i++;
                nl = i - s;
                if (active && nl >= T_RESET) begin
                    t = s + T_RESET + 2;
                    if (t < n) begin
                        exp_fd[t] = 1;
                        exp_pc[t] = 8'(idx);
                        if (bits != 0) exp_be[t] = 1;
                    end
                    idx = 0; bits = 0; sh = '0; active = 0;
                end
            end
        end
    endtask

    // mode 0: compare against model every cycle; 1: drive only;
    // 2: drop enable at sample dis_at and require quiet outputs afterwards.
    task automatic play(input int mode, input int dis_at);
        logic [63:0] a, x;
        bit prev_line;
        for (int e = 0; e < line.size(); e++) begin
            if (mode == 2 && e == dis_at) enable = 1'b0;
            serial_in = line[e];
            @(posedge clock);
            @(negedge clock);
            if (pixel_valid) cap_pv.push_back({pixel_index, pixel_data});
            if (frame_done) cap_fd.push_back({7'd0, bit_error, pixel_count});
            if (serial_out) so_high++;
            if (bit_error) be_cnt++;
            if (mode == 0) begin
                prev_line = (e >= 1) ? line[e - 1] : 1'b0;
                a = {19'd0, pixel_valid, frame_done, bit_error, serial_out, db_serial,
                     exp_pv[e] ? pixel_data : 24'd0, exp_pv[e] ? pixel_index : 8'd0,
                     exp_fd[e] ? pixel_count : 8'd0};
                x = {19'd0, exp_pv[e], exp_fd[e], exp_be[e], exp_so[e], prev_line,
                     exp_pd[e], exp_pi[e], exp_pc[e]};
                check($sformatf("cycle%0d", e), a, x);
            end else if (mode == 2 && e >= dis_at) begin
                check($sformatf("disabled%0d", e),
                      {58'd0, pixel_valid, frame_done, bit_error, serial_out, db_state}, 64'd0);
            end
        end
    endtask

    task automatic start_session();
        cap_pv.delete();
        cap_fd.delete();
        so_high = 0;
        be_cnt  = 0;
    endtask

    task automatic run_session();
        start_session();
        build_model();
        play(0, 0);
        check("end_state_idle", {62'd0, db_state}, 64'd0);
    endtask

    function automatic logic [31:0] pv_at(input int i);
        return (i < cap_pv.size()) ? cap_pv[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [15:0] fd_at(input int i);
        return (i < cap_fd.size()) ? cap_fd[i] : 16'hFFFF;
    endfunction

    task automatic check_reset_outputs(input string name);
        check(name, {17'd0, pixel_data, pixel_index, pixel_valid, frame_done, pixel_count,
                     bit_error, serial_out, db_serial, db_state}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; serial_in = 1'b0; own_words = 8'd0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset_state");
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Three-word frame, forward everything
        add_level(0, 5);
        add_word(24'h123456); add_word(24'hABCDEF); add_word(24'h000001);
        add_level(0, 2600);
        run_session();
        check("s1_words", cap_pv.size(), 3);
        check("s1_w0", pv_at(0), {8'd0, 24'h123456});
        check("s1_w1", pv_at(1), {8'd1, 24'hABCDEF});
        check("s1_w2", pv_at(2), {8'd2, 24'h000001});
        check("s1_frame", fd_at(0), {7'd0, 1'b0, 8'd3});
        check("s1_no_err", be_cnt, 0);

        // Same frame, first word consumed
        own_words = 8'd1;
        run_session();
        check("s2_so_high", so_high, 930);
        check("s2_words", cap_pv.size(), 3);
        line.delete();
        own_words = 8'd0;

        // Glitch after 10 bits, then a full good word
        add_level(0, 5);
        for (int i = 23; i >= 14; i--) begin
            logic [23:0] w;
            w = 24'h123456;
            add_level(1, w[i] ? 30 : 13);
            add_level(0, w[i] ? 32 : 49);
        end
        add_level(1, 3); add_level(0, 40);
        add_word(24'h5A5A5A);
        add_level(0, 2600);
        run_session();
        check("s3_words", cap_pv.size(), 1);
        check("s3_w0", pv_at(0), {8'd0, 24'h5A5A5A});
        check("s3_err", be_cnt, 1);
        check("s3_frame", fd_at(0), {7'd0, 1'b0, 8'd1});
        line.delete();

        // Pulse-width boundaries: 5,20 decode 0; 21,50 decode 1; 4 and 51 error
        add_level(0, 5);
        for (int i = 0; i < 24; i++) begin
            int wd[4];
            wd = '{5, 20, 21, 50};
            add_level(1, wd[i % 4]); add_level(0, 15);
        end
        add_level(1, 4);  add_level(0, 15);
        add_level(1, 51); add_level(0, 15);
        add_level(0, 2600);
        run_session();
        check("s3b_w0", pv_at(0), {8'd0, 24'h333333});
        check("s3b_err", be_cnt, 2);
        check("s3b_frame", fd_at(0), {7'd0, 1'b0, 8'd1});
        line.delete();

        // Partial word at latch
        add_level(0, 5);
        for (int i = 0; i < 12; i++) begin add_level(1, 30); add_level(0, 32); end
        add_level(0, 2600);
        run_session();
        check("s4_words", cap_pv.size(), 0);
        check("s4_frame", fd_at(0), {7'd0, 1'b1, 8'd0});
        line.delete();

        // Gap 2499 keeps the frame; gap of exactly 2500 latches
        add_level(0, 5);
        add_word(24'h00FF00, 1'b0); add_level(0, 2499);
        add_word(24'hC0FFEE, 1'b0); add_level(0, 2500);
        add_word(24'h800001);
        add_level(0, 2600);
        run_session();
        check("s5_w0", pv_at(0), {8'd0, 24'h00FF00});
        check("s5_w1", pv_at(1), {8'd1, 24'hC0FFEE});
        check("s5_w2", pv_at(2), {8'd0, 24'h800001});
        check("s5_frame0", fd_at(0), {7'd0, 1'b0, 8'd2});
        check("s5_frame1", fd_at(1), {7'd0, 1'b0, 8'd1});
        line.delete();

        // Randomized frames
        for (int r = 0; r < 2; r++) begin
            int nw;
            own_words = 8'($urandom_range(0, 3));
            nw = $urandom_range(2, 3);
            add_level(0, 5);
            for (int w = 0; w < nw; w++) begin
                logic [23:0] word;
                word = 24'($urandom);
                for (int i = 23; i >= 0; i--) begin
                    if ($urandom_range(0, 40) == 0) begin
                        add_level(1, ($urandom_range(0, 1) == 1) ? $urandom_range(51, 60)
                                                               : $urandom_range(1, 4));
                        add_level(0, 10);
                    end
                    add_level(1, word[i] ? $urandom_range(21, 50) : $urandom_range(5, 20));
                    add_level(0, $urandom_range(8, 20));
                end
            end
            add_level(0, 2600);
            run_session();
            line.delete();
        end
        own_words = 8'd0;

        // Enable dropped mid-word
        add_level(0, 5);
        for (int i = 0; i < 10; i++) begin add_level(1, 30); add_level(0, 32); end
        for (int i = 0; i < 10; i++) begin add_level(1, 30); add_level(0, 32); end
        add_level(0, 20);
        start_session();
        play(2, 5 + 10 * 62 + 15);
        line.delete();
        enable = 1'b1;
        add_level(0, 5);
        add_word(24'h0F0F0F);
        add_level(0, 2600);
        run_session();
        check("s7_w0", pv_at(0), {8'd0, 24'h0F0F0F});
        check("s7_frame", fd_at(0), {7'd0, 1'b0, 8'd1});
        line.delete();

        // Reset mid-word
        add_level(0, 5);
        for (int i = 0; i < 5; i++) begin add_level(1, 30); add_level(0, 32); end
        add_level(1, 20);
        start_session();
        play(1, 0);
        line.delete();
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        for (int i = 0; i < 10; i++) begin
            serial_in = i[0];
            @(negedge clock);
            check_reset_outputs($sformatf("reset_hold%0d", i));
        end
        serial_in = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        add_level(0, 5);
        add_word(24'h00ABCD);
        add_level(0, 2600);
        run_session();
        check("s8_w0", pv_at(0), {8'd0, 24'h00ABCD});
        check("s8_frame", fd_at(0), {7'd0, 1'b0, 8'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
